// File: rtl/branch_resolve_unit_if.sv
`default_nettype none
// ============================================================================
// Module   : branch_resolve_unit_if
// Brief    : Fetch-push, EX-resolve, predictor-update and redirect bundle for
//            the branch resolve unit.
// Revision : 1.0
// ============================================================================
interface branch_resolve_unit_if #(
    parameter int CNT_W = 32
);
    logic             fq_push_i;
    logic [31:0]      fq_pc_i;
    logic             fq_pred_taken_i;
    logic [31:0]      fq_pred_pc_i;
    logic             fq_full_o;
    logic             ex_valid_i;
    logic             ex_is_branch_i;
    logic             ex_taken_i;
    logic [31:0]      ex_target_i;
    logic             upd_branch_o;
    logic             upd_jump_o;
    logic [31:0]      upd_branch_pc_o;
    logic [31:0]      upd_target_pc_o;
    logic             redirect_o;
    logic [31:0]      redirect_pc_o;
    logic [CNT_W-1:0] branch_cnt_o;
    logic [CNT_W-1:0] mispred_cnt_o;
    logic             protocol_err_o;

    modport master (
        output fq_push_i, fq_pc_i, fq_pred_taken_i, fq_pred_pc_i,
        output ex_valid_i, ex_is_branch_i, ex_taken_i, ex_target_i,
        input  fq_full_o, upd_branch_o, upd_jump_o, upd_branch_pc_o,
        input  upd_target_pc_o, redirect_o, redirect_pc_o,
        input  branch_cnt_o, mispred_cnt_o, protocol_err_o
    );

    modport slave (
        input  fq_push_i, fq_pc_i, fq_pred_taken_i, fq_pred_pc_i,
        input  ex_valid_i, ex_is_branch_i, ex_taken_i, ex_target_i,
        output fq_full_o, upd_branch_o, upd_jump_o, upd_branch_pc_o,
        output upd_target_pc_o, redirect_o, redirect_pc_o,
        output branch_cnt_o, mispred_cnt_o, protocol_err_o
    );
endinterface
`default_nettype wire

// File: rtl/branch_resolve_unit.sv
`default_nettype none
// ============================================================================
// Module   : branch_resolve_unit
// Brief    : Queues fetch-time predictions, checks the oldest against the EX
//            outcome, trains the predictor and issues registered redirects.
// Revision : 1.0
// ============================================================================
module branch_resolve_unit #(
    parameter int QDEPTH = 4,
    parameter int CNT_W  = 32
) (
    input logic                  clk,
    input logic                  rst,
    branch_resolve_unit_if.slave bus
);
    localparam int              c_PW   = $clog2(QDEPTH);
    localparam logic [c_PW:0]   c_FULL = (c_PW+1)'(QDEPTH);
    localparam logic [c_PW:0]   c_CONE = (c_PW+1)'(1);
    localparam logic [c_PW-1:0] c_PONE = c_PW'(1);

    typedef enum logic [0:0] {
        S_NORMAL = 1'b0,
        S_SQUASH = 1'b1
    } state_t;

    state_t r_state;
    state_t w_state_nxt;

    logic [31:0] r_q_pc  [QDEPTH];
    logic        r_q_pt  [QDEPTH];
    logic [31:0] r_q_ppc [QDEPTH];

    logic [c_PW-1:0] r_wptr;
    logic [c_PW-1:0] r_rptr;
    logic [c_PW:0]   r_count;

    logic             r_upd_branch;
    logic             r_upd_jump;
    logic [31:0]      r_upd_branch_pc;
    logic [31:0]      r_upd_target_pc;
    logic             r_redirect;
    logic [31:0]      r_redirect_pc;
    logic [CNT_W-1:0] r_branch_cnt;
    logic [CNT_W-1:0] r_mispred_cnt;
    logic             r_protocol_err;

    logic        w_squash;
    logic        w_empty;
    logic        w_full;
    logic        w_push_req;
    logic        w_pop_req;
    logic        w_pop;
    logic        w_push;
    logic        w_upd;
    logic        w_err;
    logic        w_mispred;
    logic [31:0] w_redir_pc;
    logic [31:0] w_h_pc;
    logic        w_h_pt;
    logic [31:0] w_h_ppc;

    assign w_squash   = (r_state == S_SQUASH);
    assign w_empty    = (r_count == '0);
    assign w_full     = (r_count == c_FULL);
    assign w_push_req = bus.fq_push_i  && !w_squash;
    assign w_pop_req  = bus.ex_valid_i && !w_squash;
    assign w_pop      = w_pop_req && !w_empty;
    // A pop in the same cycle frees the head slot, so a full queue can still accept.
    assign w_push     = w_push_req && (!w_full || w_pop);
    assign w_upd      = w_pop && bus.ex_is_branch_i;
    assign w_err      = (w_pop_req && w_empty) || (w_push_req && w_full && !w_pop);

    assign w_h_pc  = r_q_pc[r_rptr];
    assign w_h_pt  = r_q_pt[r_rptr];
    assign w_h_ppc = r_q_ppc[r_rptr];

    always_comb begin
        w_mispred  = 1'b0;
        w_redir_pc = '0;
        if (w_pop) begin
            if (bus.ex_is_branch_i) begin
                if (bus.ex_taken_i) begin
                    if (!w_h_pt || (w_h_ppc != bus.ex_target_i)) begin
                        w_mispred  = 1'b1;
                        w_redir_pc = bus.ex_target_i;
                    end
                end else if (w_h_pt) begin
                    w_mispred  = 1'b1;
                    w_redir_pc = w_h_pc + 32'd4;
                end
            end else if (w_h_pt) begin
                // Predictor aliased a non-branch as taken; fall through instead.
                w_mispred  = 1'b1;
                w_redir_pc = w_h_pc + 32'd4;
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_NORMAL: if (w_mispred) w_state_nxt = S_SQUASH;
            S_SQUASH: w_state_nxt = S_NORMAL;
            default:  w_state_nxt = S_NORMAL;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) r_state <= S_NORMAL;
        else     r_state <= w_state_nxt;
    end

    always_ff @(posedge clk) begin
        if (w_push && !w_mispred && !rst) begin
            r_q_pc[r_wptr]  <= bus.fq_pc_i;
            r_q_pt[r_wptr]  <= bus.fq_pred_taken_i;
            r_q_ppc[r_wptr] <= bus.fq_pred_pc_i;
        end
    end

    // A mispredict discards everything younger, including a same-cycle push.
    always_ff @(posedge clk) begin
        if (rst || w_mispred) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) r_wptr <= r_wptr + c_PONE;
            if (w_pop)  r_rptr <= r_rptr + c_PONE;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + c_CONE;
                2'b01:   r_count <= r_count - c_CONE;
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_upd_branch    <= 1'b0;
            r_upd_jump      <= 1'b0;
            r_upd_branch_pc <= '0;
            r_upd_target_pc <= '0;
            r_redirect      <= 1'b0;
            r_redirect_pc   <= '0;
            r_branch_cnt    <= '0;
            r_mispred_cnt   <= '0;
            r_protocol_err  <= 1'b0;
        end else begin
            r_upd_branch    <= w_upd;
            r_upd_jump      <= w_upd ? bus.ex_taken_i  : 1'b0;
            r_upd_branch_pc <= w_upd ? w_h_pc          : 32'd0;
            r_upd_target_pc <= w_upd ? bus.ex_target_i : 32'd0;
            r_redirect      <= w_mispred;
            r_redirect_pc   <= w_redir_pc;
            if (w_upd)     r_branch_cnt  <= r_branch_cnt  + CNT_W'(1);
            if (w_mispred) r_mispred_cnt <= r_mispred_cnt + CNT_W'(1);
            if (w_err)     r_protocol_err <= 1'b1;
        end
    end

    assign bus.fq_full_o       = w_full;
    assign bus.upd_branch_o    = r_upd_branch;
    assign bus.upd_jump_o      = r_upd_jump;
    assign bus.upd_branch_pc_o = r_upd_branch_pc;
    assign bus.upd_target_pc_o = r_upd_target_pc;
    assign bus.redirect_o      = r_redirect;
    assign bus.redirect_pc_o   = r_redirect_pc;
    assign bus.branch_cnt_o    = r_branch_cnt;
    assign bus.mispred_cnt_o   = r_mispred_cnt;
    assign bus.protocol_err_o  = r_protocol_err;
endmodule
`default_nettype wire

// File: tb/tb_branch_resolve_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_branch_resolve_unit
// Brief    : Directed vector table plus hand sequences for branch_resolve_unit.
// Revision : 1.0
// ============================================================================
module tb_branch_resolve_unit;
    logic clk;
    logic rst;
    int   n_vec;
    int   n_err;

    branch_resolve_unit_if #(.CNT_W(32)) bus ();

    branch_resolve_unit #(.QDEPTH(4), .CNT_W(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        push;
        logic [31:0] pc;
        logic        pt;
        logic [31:0] ppc;
        logic        exv;
        logic        br;
        logic        tk;
        logic [31:0] tgt;
        logic        e_upd;
        logic        e_jmp;
        logic [31:0] e_bpc;
        logic [31:0] e_tpc;
        logic        e_red;
        logic [31:0] e_rpc;
        logic        e_full;
        logic        e_err;
        logic [31:0] e_bcnt;
        logic [31:0] e_mcnt;
    } vec_t;

    vec_t vt [20];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Drive one cycle of inputs, then sample #1 after the edge.
    task automatic cyc(input logic push, input logic [31:0] pc, input logic pt,
                       input logic [31:0] ppc, input logic exv, input logic br,
                       input logic tk, input logic [31:0] tgt);
        bus.fq_push_i       = push;
        bus.fq_pc_i         = pc;
        bus.fq_pred_taken_i = pt;
        bus.fq_pred_pc_i    = ppc;
        bus.ex_valid_i      = exv;
        bus.ex_is_branch_i  = br;
        bus.ex_taken_i      = tk;
        bus.ex_target_i     = tgt;
        @(posedge clk);
        #1;
        n_vec++;
    endtask

    task automatic idle_inputs();
        bus.fq_push_i = 0; bus.fq_pc_i = 0; bus.fq_pred_taken_i = 0; bus.fq_pred_pc_i = 0;
        bus.ex_valid_i = 0; bus.ex_is_branch_i = 0; bus.ex_taken_i = 0; bus.ex_target_i = 0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, ".upd"},  32'(bus.upd_branch_o),   32'd0);
        chk({tag, ".jmp"},  32'(bus.upd_jump_o),     32'd0);
        chk({tag, ".bpc"},  bus.upd_branch_pc_o,     32'd0);
        chk({tag, ".tpc"},  bus.upd_target_pc_o,     32'd0);
        chk({tag, ".red"},  32'(bus.redirect_o),     32'd0);
        chk({tag, ".rpc"},  bus.redirect_pc_o,       32'd0);
        chk({tag, ".full"}, 32'(bus.fq_full_o),      32'd0);
        chk({tag, ".err"},  32'(bus.protocol_err_o), 32'd0);
        chk({tag, ".bcnt"}, bus.branch_cnt_o,        32'd0);
        chk({tag, ".mcnt"}, bus.mispred_cnt_o,       32'd0);
    endtask

    initial begin
        logic [31:0] mq [$];
        logic [31:0] head;
        logic [31:0] ppc;
        n_vec = 0;
        n_err = 0;

        //         push pc        pt ppc        exv br tk tgt         upd jmp bpc       tpc        red rpc        full err bcnt mcnt
        vt[0]  = '{1, 32'h100, 0, 32'h0,   0, 0, 0, 32'h0,   0, 0, 32'h0,   32'h0,   0, 32'h0,   0, 0, 0, 0};
        vt[1]  = '{0, 32'h0,   0, 32'h0,   1, 1, 0, 32'h0,   1, 0, 32'h100, 32'h0,   0, 32'h0,   0, 0, 1, 0};
        vt[2]  = '{1, 32'h200, 1, 32'h280, 0, 0, 0, 32'h0,   0, 0, 32'h0,   32'h0,   0, 32'h0,   0, 0, 1, 0};
        vt[3]  = '{1, 32'h900, 0, 32'h0,   1, 1, 1, 32'h300, 1, 1, 32'h200, 32'h300, 1, 32'h300, 0, 0, 2, 1};
        vt[4]  = '{1, 32'hA00, 1, 32'hA80, 1, 1, 0, 32'h0,   0, 0, 32'h0,   32'h0,   0, 32'h0,   0, 0, 2, 1};
        vt[5]  = '{1, 32'h500, 0, 32'h0,   0, 0, 0, 32'h0,   0, 0, 32'h0,   32'h0,   0, 32'h0,   0, 0, 2, 1};
        vt[6]  = '{0, 32'h0,   0, 32'h0,   1, 1, 0, 32'h0,   1, 0, 32'h500, 32'h0,   0, 32'h0,   0, 0, 3, 1};
        vt[7]  = '{1, 32'h400, 1, 32'h480, 0, 0, 0, 32'h0,   0, 0, 32'h0,   32'h0,   0, 32'h0,   0, 0, 3, 1};
        vt[8]  = '{0, 32'h0,   0, 32'h0,   1, 0, 0, 32'h0,   0, 0, 32'h0,   32'h0,   1, 32'h404, 0, 0, 3, 2};
        vt[9]  = '{0, 32'h0,   0, 32'h0,   0, 0, 0, 32'h0,   0, 0, 32'h0,   32'h0,   0, 32'h0,   0, 0, 3, 2};
        vt[10] = '{1, 32'h10,  0, 32'h0,   0, 0, 0, 32'h0,   0, 0, 32'h0,   32'h0,   0, 32'h0,   0, 0, 3, 2};
        vt[11] = '{1, 32'h14,  0, 32'h0,   0, 0, 0, 32'h0,   0, 0, 32'h0,   32'h0,   0, 32'h0,   0, 0, 3, 2};
        vt[12] = '{1, 32'h18,  0, 32'h0,   0, 0, 0, 32'h0,   0, 0, 32'h0,   32'h0,   0, 32'h0,   0, 0, 3, 2};
        vt[13] = '{1, 32'h1C,  0, 32'h0,   0, 0, 0, 32'h0,   0, 0, 32'h0,   32'h0,   0, 32'h0,   1, 0, 3, 2};
        vt[14] = '{1, 32'h20,  0, 32'h0,   1, 1, 0, 32'h0,   1, 0, 32'h10,  32'h0,   0, 32'h0,   1, 0, 4, 2};
        vt[15] = '{1, 32'h24,  0, 32'h0,   0, 0, 0, 32'h0,   0, 0, 32'h0,   32'h0,   0, 32'h0,   1, 1, 4, 2};
        vt[16] = '{0, 32'h0,   0, 32'h0,   1, 1, 0, 32'h0,   1, 0, 32'h14,  32'h0,   0, 32'h0,   0, 1, 5, 2};
        vt[17] = '{0, 32'h0,   0, 32'h0,   1, 1, 0, 32'h0,   1, 0, 32'h18,  32'h0,   0, 32'h0,   0, 1, 6, 2};
        vt[18] = '{0, 32'h0,   0, 32'h0,   1, 1, 0, 32'h0,   1, 0, 32'h1C,  32'h0,   0, 32'h0,   0, 1, 7, 2};
        vt[19] = '{0, 32'h0,   0, 32'h0,   1, 1, 0, 32'h0,   1, 0, 32'h20,  32'h0,   0, 32'h0,   0, 1, 8, 2};

        do_reset();
        chk_all_zero("reset");

        for (int i = 0; i < 20; i++) begin
            cyc(vt[i].push, vt[i].pc, vt[i].pt, vt[i].ppc,
                vt[i].exv, vt[i].br, vt[i].tk, vt[i].tgt);
            chk($sformatf("v%0d.upd", i),  32'(bus.upd_branch_o),   32'(vt[i].e_upd));
            chk($sformatf("v%0d.jmp", i),  32'(bus.upd_jump_o),     32'(vt[i].e_jmp));
            chk($sformatf("v%0d.bpc", i),  bus.upd_branch_pc_o,     vt[i].e_bpc);
            chk($sformatf("v%0d.tpc", i),  bus.upd_target_pc_o,     vt[i].e_tpc);
            chk($sformatf("v%0d.red", i),  32'(bus.redirect_o),     32'(vt[i].e_red));
            chk($sformatf("v%0d.rpc", i),  bus.redirect_pc_o,       vt[i].e_rpc);
            chk($sformatf("v%0d.full", i), 32'(bus.fq_full_o),      32'(vt[i].e_full));
            chk($sformatf("v%0d.err", i),  32'(bus.protocol_err_o), 32'(vt[i].e_err));
            chk($sformatf("v%0d.bcnt", i), bus.branch_cnt_o,        vt[i].e_bcnt);
            chk($sformatf("v%0d.mcnt", i), bus.mispred_cnt_o,       vt[i].e_mcnt);
        end

        // Lockstep push/pop of 10 correctly predicted taken branches across pointer wrap.
        for (int k = 0; k <= 10; k++) begin
            logic        do_pop;
            logic        do_push;
            logic [31:0] pc;
            do_pop  = (k > 0);
            do_push = (k < 10);
            pc      = 32'h1000 + 32'(k) * 32'd4;
            head    = do_pop ? mq[0] : 32'h0;
            cyc(do_push, pc, 1'b1, pc + 32'h40, do_pop, 1'b1, 1'b1, head + 32'h40);
            if (do_push) mq.push_back(pc);
            if (do_pop) begin
                void'(mq.pop_front());
                chk($sformatf("wrap%0d.upd", k), 32'(bus.upd_branch_o), 32'd1);
                chk($sformatf("wrap%0d.jmp", k), 32'(bus.upd_jump_o),   32'd1);
                chk($sformatf("wrap%0d.bpc", k), bus.upd_branch_pc_o,   head);
                chk($sformatf("wrap%0d.tpc", k), bus.upd_target_pc_o,   head + 32'h40);
                chk($sformatf("wrap%0d.red", k), 32'(bus.redirect_o),   32'd0);
            end
        end
        chk("wrap.bcnt", bus.branch_cnt_o,        32'd18);
        chk("wrap.mcnt", bus.mispred_cnt_o,       32'd2);
        chk("wrap.err",  32'(bus.protocol_err_o), 32'd1);

        // Reset in the cycle after a mispredict resolve wins over the pending redirect.
        do_reset();
        chk_all_zero("reset2");
        ppc = 32'h780;
        cyc(1'b1, 32'h700, 1'b1, ppc, 1'b0, 1'b0, 1'b0, 32'h0);
        cyc(1'b1, 32'h704, 1'b0, 32'h0, 1'b1, 1'b1, 1'b0, 32'h0);
        chk("mp.red",  32'(bus.redirect_o), 32'd1);
        chk("mp.rpc",  bus.redirect_pc_o,   32'h704);
        chk("mp.mcnt", bus.mispred_cnt_o,   32'd1);
        idle_inputs();
        rst = 1'b1;
        @(posedge clk);
        #1;
        n_vec++;
        rst = 1'b0;
        chk_all_zero("rstmp");

        // Queue must be empty: the next push is the next head.
        cyc(1'b1, 32'h800, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0);
        cyc(1'b0, 32'h0,   1'b0, 32'h0, 1'b1, 1'b1, 1'b0, 32'h0);
        chk("post.upd", 32'(bus.upd_branch_o), 32'd1);
        chk("post.bpc", bus.upd_branch_pc_o,   32'h800);
        chk("post.err", 32'(bus.protocol_err_o), 32'd0);

        // Pop on empty: no outputs, sticky error.
        cyc(1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 1'b1, 1'b1, 32'h40);
        chk("empty.upd",  32'(bus.upd_branch_o),   32'd0);
        chk("empty.red",  32'(bus.redirect_o),     32'd0);
        chk("empty.bcnt", bus.branch_cnt_o,        32'd1);
        chk("empty.err",  32'(bus.protocol_err_o), 32'd1);
        cyc(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0);
        chk("sticky.err", 32'(bus.protocol_err_o), 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/branch_resolve_unit.md
# branch_resolve_unit

Execute-side counterpart of the fetch-stage branch predictor. It records every prediction issued at fetch in an in-order queue and compares the oldest entry against the outcome resolved in EX. It then generates the predictor's training-update stream and a registered pipeline redirect on misprediction. The block sits between IF (push side), EX (resolve side), the predictor update port, and the PC/flush control.

## Interface
- QDEPTH, 4: in-flight prediction queue depth. Power of two, ≥2.
- CNT_W, 32: width of the statistics counters.

- clk  in  1  clock
- rst  in  1  reset; synchronous, active-high
- fq_push_i  in  1  fetch issued one instruction this cycle; record its prediction
- fq_pc_i  in  32  PC of the fetched instruction
- fq_pred_taken_i  in  1  predictor said taken
- fq_pred_pc_i  in  32  predicted target (don't-care if not taken)
- fq_full_o  out  1  queue full; fetch must stall (combinational from count)
- ex_valid_i  in  1  oldest in-flight instruction resolves in EX this cycle
- ex_is_branch_i  in  1  resolved instruction is a branch/jump
- ex_taken_i  in  1  actual direction
- ex_target_i  in  32  actual target (valid when ex_taken_i)
- upd_branch_o  out  1  predictor update strobe (drives predictor branch_i)
- upd_jump_o  out  1  actual taken (predictor jump_i)
- upd_branch_pc_o  out  32  branch PC (predictor branch_pc_i)
- upd_target_pc_o  out  32  actual target (predictor target_pc_i)
- redirect_o  out  1  mispredict; flush younger stages, load redirect_pc_o
- redirect_pc_o  out  32  correct next PC
- branch_cnt_o  out  CNT_W  resolved branches
- mispred_cnt_o  out  CNT_W  mispredictions (branch and non-branch)
- protocol_err_o  out  1  sticky: pop on empty or push on full

## Operation
- Queue: circular buffer, QDEPTH entries of {pc, pred_taken, pred_pc}. Read/write pointers are log2(QDEPTH) bits and wrap naturally. Count is log2(QDEPTH)+1 bits.
- Push writes at the write pointer when fq_push_i is high and not squashing. Pop reads the head when ex_valid_i is high and not squashing.
- Push and pop in the same cycle are allowed at any count, including full: the pop frees the slot and the count is unchanged.
- Push when full with no pop: entry dropped, protocol_err_o set.
- Pop when empty: ignored, no outputs generated, protocol_err_o set.
- Mispredict evaluation on a valid pop, head entry H:
  - Branch, taken, and (!H.pred_taken or H.pred_pc≠ex_target_i): redirect to ex_target_i.
  - Branch, not taken, H.pred_taken: redirect to H.pc+4.
  - Non-branch, H.pred_taken (aliasing): redirect to H.pc+4.
  - Otherwise: no redirect.
- Update: on every valid pop with ex_is_branch_i, upd_branch_o=1 with {ex_taken_i, H.pc, ex_target_i}. Non-branch pops produce no update.
- Mispredict: the queue is cleared (pointers and count to 0). All younger entries are wrong-path.
- Counters: branch_cnt_o increments per branch pop. mispred_cnt_o increments per redirect. Both wrap modulo 2^CNT_W.
- States: NORMAL and SQUASH.
  - NORMAL→SQUASH on a mispredict.
  - SQUASH→NORMAL after exactly one cycle.
  - In SQUASH, fq_push_i and ex_valid_i are ignored (wrong-path) and never flag an error.

## Timing
- Reset values: all outputs 0, queue empty, state NORMAL, counters 0, protocol_err_o 0. Only rst clears protocol_err_o.
- Resolve in cycle T:
  - upd_* and redirect_* are registered and valid in cycle T+1, each for exactly one cycle.
  - Counters are updated at the end of T.
- Mispredict in T:
  - Queue cleared at the end of T.
  - Pushes in T are discarded; the clear wins over a same-cycle push.
  - SQUASH occupies T+1, so pushes/pops in T+1 are ignored.
  - The first accepted push is in T+2, when fetch presents the redirect target.
- fq_full_o reflects the count in the current cycle. It does not account for a same-cycle pop.
- Mid-operation rst overrides everything, including a pending redirect: outputs are 0 in the next cycle.

## Test plan
- Reset, then push PC 0x100 pred not-taken and resolve as branch not taken → T+1: upd_branch_o=1, upd_jump_o=0, upd_branch_pc_o=0x100, redirect_o=0, branch_cnt_o=1.
- Push 0x200 pred taken→0x280 and resolve taken target 0x300 → T+1: redirect_o=1, redirect_pc_o=0x300, upd_target_pc_o=0x300, mispred_cnt_o=1. Prior queued entries are gone, and a push in T+1 is ignored (queue empty in T+2).
- Push 0x400 pred taken and resolve as non-branch → redirect_pc_o=0x404, upd_branch_o=0.
- Push 4 entries (QDEPTH=4) → fq_full_o=1. A 5th push with no pop sets protocol_err_o. A same-cycle push+pop at full keeps the count at 4, err stays 0.
- Push/pop 10 entries in lockstep across pointer wrap → updates emerge in FIFO order with the correct PCs.
- Assert rst in the cycle after a mispredict resolve → redirect_o=0 next cycle, counters 0, queue empty.
